// File: rtl/ulpb_rx_msg_buffer_pkg.sv
// rtl/ulpb_rx_msg_buffer_pkg.sv - shared widths, entry layout and ACK FSM states
package ulpb_rx_msg_buffer_pkg;

  localparam int RXB_ADDR_W = 8;
  localparam int RXB_DATA_W = 32;

  // Entry layout {err, last, addr, data}; the layer controller decodes with these offsets
  localparam int RXB_LAST_BIT = RXB_ADDR_W + RXB_DATA_W;
  localparam int RXB_ERR_BIT  = RXB_ADDR_W + RXB_DATA_W + 1;
  localparam int RXB_ENTRY_W  = RXB_ADDR_W + RXB_DATA_W + 2;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_HIGH = 1'b1
  } ack_state_e;

endpackage

// File: rtl/ulpb_rx_msg_buffer_if.sv
// rtl/ulpb_rx_msg_buffer_if.sv - node RX handshake plus layer-side message stream
interface ulpb_rx_msg_buffer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LVL_W  = 4
);
  logic [ADDR_W-1:0] rx_addr;
  logic [DATA_W-1:0] rx_data;
  logic              rx_req;
  logic              rx_pend;
  logic              rx_ack;
  logic              msg_valid;
  logic [ADDR_W-1:0] msg_addr;
  logic [DATA_W-1:0] msg_data;
  logic              msg_last;
  logic              msg_err;
  logic              msg_ready;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  rx_addr, rx_data, rx_req, rx_pend, msg_ready,
    output rx_ack, msg_valid, msg_addr, msg_data, msg_last, msg_err, fifo_level
  );

  modport master (
    output rx_addr, rx_data, rx_req, rx_pend, msg_ready,
    input  rx_ack, msg_valid, msg_addr, msg_data, msg_last, msg_err, fifo_level
  );
endinterface

// File: rtl/ulpb_rx_msg_buffer_sync_fifo.sv
// rtl/ulpb_rx_msg_buffer_sync_fifo.sv - synchronous FIFO with level count and zeroed empty head
module ulpb_sync_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Power-of-two depth lets the pointers wrap on their own
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/ulpb_rx_msg_buffer.sv
// rtl/ulpb_rx_msg_buffer.sv - four-phase RX word intake, message framing/timeout, buffered stream out
module ulpb_rx_msg_buffer
  import ulpb_rx_msg_buffer_pkg::*;
#(
  parameter int ADDR_W  = RXB_ADDR_W,
  parameter int DATA_W  = RXB_DATA_W,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  ulpb_rx_msg_buffer_if.slave bus
);
  localparam int W     = ADDR_W + DATA_W + 2;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  ack_state_e        state_q, state_d;
  logic              in_msg_q, in_msg_d;
  logic              abort_pend_q, abort_pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

  logic              accept, abort_push, push, pop, full, empty;
  logic [W-1:0]      wdata, rdata;
  logic [LVL_W-1:0]  level;

  assign accept     = (state_q == ACK_IDLE) & bus.rx_req & ~full & ~abort_pend_q;
  assign abort_push = abort_pend_q & ~full;
  assign push       = accept | abort_push;
  assign pop        = ~empty & bus.msg_ready;
  assign wdata      = abort_push ? {2'b11, cur_addr_q, {DATA_W{1'b0}}}
                                 : {1'b0, ~bus.rx_pend, bus.rx_addr, bus.rx_data};

  always_comb begin
    state_d      = state_q;
    in_msg_d     = in_msg_q;
    abort_pend_d = abort_pend_q;
    cnt_d        = cnt_q;
    cur_addr_d   = cur_addr_q;

    case (state_q)
      ACK_IDLE: if (accept) state_d = ACK_HIGH;
      ACK_HIGH: if (!bus.rx_req) state_d = ACK_IDLE;
      default:  state_d = ACK_IDLE;
    endcase

    if (accept) begin
      in_msg_d   = bus.rx_pend;
      cur_addr_d = bus.rx_addr;
      cnt_d      = '0;
    end else if (in_msg_q && !bus.rx_req) begin
      // Open message gone quiet: close it and queue an abort marker
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        abort_pend_d = 1'b1;
        in_msg_d     = 1'b0;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!in_msg_q) begin
      cnt_d = '0;
    end

    if (abort_push) begin
      abort_pend_d = 1'b0;
      in_msg_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACK_IDLE;
      in_msg_q     <= 1'b0;
      abort_pend_q <= 1'b0;
      cnt_q        <= '0;
      cur_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      in_msg_q     <= in_msg_d;
      abort_pend_q <= abort_pend_d;
      cnt_q        <= cnt_d;
      cur_addr_q   <= cur_addr_d;
    end
  end

  ulpb_sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign bus.rx_ack     = (state_q == ACK_HIGH);
  assign bus.msg_valid  = ~empty;
  assign bus.msg_err    = rdata[W-1];
  assign bus.msg_last   = rdata[W-2];
  assign bus.msg_addr   = rdata[DATA_W +: ADDR_W];
  assign bus.msg_data   = rdata[DATA_W-1:0];
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_ulpb_rx_msg_buffer.sv
// tb/tb_ulpb_rx_msg_buffer.sv - directed scoreboard bench for ulpb_rx_msg_buffer
module tb_ulpb_rx_msg_buffer;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [41:0] exp_q[$];

  ulpb_rx_msg_buffer_if #(.ADDR_W(8), .DATA_W(32), .LVL_W(4)) bus ();

  ulpb_rx_msg_buffer #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Popped entries are checked against the scoreboard mid-cycle, away from the clock edge
  always @(negedge clk) begin
    if (!rst && bus.msg_valid === 1'b1 && bus.msg_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_underflow observed=%0h expected=none",
               {bus.msg_err, bus.msg_last, bus.msg_addr, bus.msg_data});
      end else begin
        chk("entry", {bus.msg_err, bus.msg_last, bus.msg_addr, bus.msg_data}, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [31:0] d, input logic p);
    int n;
    bus.rx_addr = a;
    bus.rx_data = d;
    bus.rx_pend = p;
    bus.rx_req  = 1'b1;
    exp_q.push_back({1'b0, ~p, a, d});
    n = 0;
    while (bus.rx_ack !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("ack_rise", bus.rx_ack, 1);
    bus.rx_req = 1'b0;
    step();
    chk("ack_fall", bus.rx_ack, 0);
  endtask

  task automatic drain();
    int n;
    bus.msg_ready = 1'b1;
    n = 0;
    while (bus.fifo_level !== 4'd0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_level", bus.fifo_level, 0);
    bus.msg_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.rx_addr   = '0;
    bus.rx_data   = '0;
    bus.rx_req    = 1'b0;
    bus.rx_pend   = 1'b0;
    bus.msg_ready = 1'b0;
    step();
    step();
    chk("rst_ack", bus.rx_ack, 0);
    chk("rst_valid", bus.msg_valid, 0);
    chk("rst_fields", {bus.msg_err, bus.msg_last, bus.msg_addr, bus.msg_data}, 0);
    chk("rst_level", bus.fifo_level, 0);
    rst = 1'b0;
    step();

    // Single-word message, one-cycle ACK latency
    bus.rx_addr = 8'h12;
    bus.rx_data = 32'hDEADBEEF;
    bus.rx_pend = 1'b0;
    bus.rx_req  = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h12, 32'hDEADBEEF});
    step();
    chk("single_ack", bus.rx_ack, 1);
    chk("single_level", bus.fifo_level, 1);
    chk("single_valid", bus.msg_valid, 1);
    bus.rx_req = 1'b0;
    step();
    chk("single_ack_fall", bus.rx_ack, 0);
    bus.msg_ready = 1'b1;
    step();
    bus.msg_ready = 1'b0;
    chk("single_level_pop", bus.fifo_level, 0);
    chk("single_valid_pop", bus.msg_valid, 0);

    // Three-word message streamed with the consumer always ready
    bus.msg_ready = 1'b1;
    send(8'h21, 32'h0000_0001, 1'b1);
    send(8'h21, 32'h0000_0002, 1'b1);
    send(8'h21, 32'h0000_0003, 1'b0);
    drain();

    // Back-pressure: ninth word held until one entry is popped
    for (int i = 0; i < DEPTH; i++) send(8'h40 + 8'(i), 32'hA000_0000 + i, 1'b1);
    chk("full_level", bus.fifo_level, DEPTH);
    bus.rx_addr = 8'h48;
    bus.rx_data = 32'hA000_0008;
    bus.rx_pend = 1'b0;
    bus.rx_req  = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h48, 32'hA000_0008});
    for (int i = 0; i < 2; i++) begin
      step();
      chk("full_hold_ack", bus.rx_ack, 0);
      chk("full_hold_level", bus.fifo_level, DEPTH);
    end
    bus.msg_ready = 1'b1;
    step();
    bus.msg_ready = 1'b0;
    chk("full_pop_ack", bus.rx_ack, 0);
    chk("full_pop_level", bus.fifo_level, DEPTH - 1);
    step();
    chk("full_late_ack", bus.rx_ack, 1);
    chk("full_refill_level", bus.fifo_level, DEPTH);
    bus.rx_req = 1'b0;
    step();
    chk("full_ack_fall", bus.rx_ack, 0);
    drain();

    // Open message times out; a word arriving with the abort pending waits behind it
    send(8'h34, 32'h1111_2222, 1'b1);
    repeat (TIMEOUT - 1) step();
    chk("to_before_abort", bus.fifo_level, 1);
    exp_q.push_back({1'b1, 1'b1, 8'h34, 32'h0});
    bus.rx_addr = 8'h56;
    bus.rx_data = 32'h3333_4444;
    bus.rx_pend = 1'b0;
    bus.rx_req  = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h56, 32'h3333_4444});
    step();
    chk("to_abort_level", bus.fifo_level, 2);
    chk("to_abort_ack", bus.rx_ack, 0);
    step();
    chk("to_word_ack", bus.rx_ack, 1);
    chk("to_word_level", bus.fifo_level, 3);
    bus.rx_req = 1'b0;
    step();
    drain();

    // Reset mid-handshake with three entries buffered
    send(8'h70, 32'h7000_0000, 1'b0);
    send(8'h71, 32'h7000_0001, 1'b0);
    bus.rx_addr = 8'h72;
    bus.rx_data = 32'h7000_0002;
    bus.rx_req  = 1'b1;
    step();
    chk("pre_rst_ack", bus.rx_ack, 1);
    chk("pre_rst_level", bus.fifo_level, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", bus.rx_ack, 0);
    chk("mid_rst_valid", bus.msg_valid, 0);
    chk("mid_rst_level", bus.fifo_level, 0);
    exp_q.delete();
    bus.rx_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    send(8'h7A, 32'hCAFE_F00D, 1'b0);
    drain();

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
